// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: definitions shared by the instruction-fetch stage.
//   fetch_state_t    - fetch FSM states (REQ: request on the bus, HOLD: buffer full)
//   PC_INIT_DEFAULT  - default first fetch address after reset
//   NOP_INST         - addi x0,x0,0, the buffer contents after reset
//   IBUS_DATA_W      - width of the instruction bus response data
//   INST_BYTES       - size of one instruction word in bytes
package fetch_unit_pkg;

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    localparam logic [63:0] PC_INIT_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST        = 32'h0000_0013;
    localparam int          IBUS_DATA_W     = 32;
    localparam int          INST_BYTES      = 4;

endpackage

// File: rtl/fetch_unit_inst_buffer.sv
// fetch_unit_inst_buffer: one-entry holding register for a fetched instruction.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   load                - capture load_inst/load_pc and mark the entry valid
//   pop                 - decode consumed the entry; mark it empty
//   flush               - discard the entry (redirect); wins over load and pop
//   load_inst, load_pc  - incoming instruction word and its address
//   valid, inst, pc     - current entry
import fetch_unit_pkg::*;

module fetch_unit_inst_buffer #(
    parameter int XLEN = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [IBUS_DATA_W-1:0] load_inst,
    input  logic [XLEN-1:0]        load_pc,
    output logic                   valid,
    output logic [IBUS_DATA_W-1:0] inst,
    output logic [XLEN-1:0]        pc
);

    // inst/pc are left untouched on flush and pop: only valid qualifies them,
    // and keeping them frozen gives stable outputs under back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: registers take non-blocking (<=) assignments so every flop
            // samples its inputs from before the edge, independent of order.
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            // A load may coincide with a pop of the old entry; the new one wins.
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues one word fetch at a
// time on the instruction bus, buffers the returned word for one entry and hands
// it to decode over a valid/ready handshake. Execute can redirect the PC.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   ibus_req_valid, ibus_req_addr    - fetch request (held until data_ok)
//   ibus_resp_addr_ok                - address accepted (informational)
//   ibus_resp_data_ok, ibus_resp_data- response strobe and instruction word
//   inst_valid, inst_ready           - handshake towards decode
//   inst, inst_pc                    - instruction word and its address
//   redirect_valid, redirect_pc      - PC change from execute (bits [1:0] ignored)
import fetch_unit_pkg::*;

module fetch_unit #(
    parameter int              XLEN    = 64,
    parameter logic [XLEN-1:0] PC_INIT = XLEN'(PC_INIT_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ibus_req_valid,
    output logic [XLEN-1:0]        ibus_req_addr,
    input  logic                   ibus_resp_addr_ok,
    input  logic                   ibus_resp_data_ok,
    input  logic [IBUS_DATA_W-1:0] ibus_resp_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [IBUS_DATA_W-1:0] inst,
    output logic [XLEN-1:0]        inst_pc,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic            kill, kill_next;
    logic [XLEN-1:0] kill_addr;  // address of the in-flight request that was killed
    logic            resp_fire;
    logic            buf_load;
    logic            buf_pop;
    logic            unused_inputs;

    assign unused_inputs = ^{ibus_resp_addr_ok, redirect_pc[1:0]};

    // In REQ with the buffer still full (the previous load saw inst_ready),
    // the request waits until the buffer drains so a response can never land
    // on an unconsumed instruction. Once raised it stays up: the buffer is
    // empty from the next cycle on until this request's own response.
    assign ibus_req_valid = !reset && (state == REQ) && (!inst_valid || inst_ready);
    // A killed request keeps its original address on the bus while pc already
    // holds the redirect target.
    assign ibus_req_addr  = kill ? kill_addr : pc;

    assign resp_fire = ibus_req_valid && ibus_resp_data_ok;
    assign buf_load  = resp_fire && !kill && !redirect_valid;
    assign buf_pop   = inst_valid && inst_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        pc_next    = pc;
        kill_next  = kill;
        if (redirect_valid) begin
            state_next = REQ;
            pc_next    = {redirect_pc[XLEN-1:2], 2'b00};
            // Only a request that does not end this cycle is still in flight.
            kill_next  = ibus_req_valid && !ibus_resp_data_ok;
        end else if (resp_fire) begin
            if (kill) begin
                kill_next = 1'b0;
            end else begin
                pc_next    = pc + XLEN'(INST_BYTES);
                state_next = inst_ready ? REQ : HOLD;
            end
        end else if (state == HOLD && buf_pop) begin
            state_next = REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ;
            pc        <= PC_INIT;
            kill      <= 1'b0;
            kill_addr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            kill  <= kill_next;
            // While not killed, the outstanding address is pc; freeze it on kill.
            if (!kill) begin
                kill_addr <= pc;
            end
        end
    end

    fetch_unit_inst_buffer #(
        .XLEN (XLEN)
    ) u_inst_buffer (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .load_inst (ibus_resp_data),
        .load_pc   (pc),
        .valid     (inst_valid),
        .inst      (inst),
        .pc        (inst_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the stage
// (outstanding request record, one-entry buffer, pc, drain-wait flag).
module tb_fetch_unit;

    localparam logic [63:0] PC0 = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ibus_req_valid;
    logic [63:0] ibus_req_addr;
    logic        ibus_resp_addr_ok;
    logic        ibus_resp_data_ok;
    logic [31:0] ibus_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN    (64),
        .PC_INIT (PC0)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ibus_req_valid    (ibus_req_valid),
        .ibus_req_addr     (ibus_req_addr),
        .ibus_resp_addr_ok (ibus_resp_addr_ok),
        .ibus_resp_data_ok (ibus_resp_data_ok),
        .ibus_resp_data    (ibus_resp_data),
        .inst_valid        (inst_valid),
        .inst_ready        (inst_ready),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    logic        m_buf_v;
    logic [31:0] m_inst;
    logic [63:0] m_inst_pc;
    logic [63:0] m_pc;
    logic        m_live;      // a request is on the bus and has not ended
    logic [63:0] m_req_addr;  // its address
    logic        m_killed;    // it was overtaken by a redirect
    logic        m_wait;      // a load saw no ready: wait for the drain first
    logic        exp_req;
    logic [63:0] exp_addr;

    // Bus responder settings.
    int          age;
    int          lat;
    logic        rand_lat;
    logic        fixed_data_en;
    logic [31:0] fixed_data;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_buf_v   = 1'b0;
        m_inst    = NOP;
        m_inst_pc = '0;
        m_pc      = PC0;
        m_live    = 1'b0;
        m_killed  = 1'b0;
        m_wait    = 1'b0;
        m_req_addr = '0;
        age       = 0;
    endtask

    // Drive one cycle of inputs, let outputs settle, compare with the model.
    task automatic apply(input logic r, input logic rv, input logic [63:0] tgt, input logic rdy);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = tgt;
        inst_ready     = rdy;
        exp_req  = !r && (m_live || (!m_wait && (!m_buf_v || rdy)));
        exp_addr = m_live ? m_req_addr : m_pc;
        ibus_resp_data_ok = r ? ($urandom_range(0, 1) == 1) : (exp_req && age >= lat);
        ibus_resp_data    = fixed_data_en ? fixed_data : $urandom;
        ibus_resp_addr_ok = exp_req;
        #1;
        check("req_valid", {63'd0, ibus_req_valid}, {63'd0, exp_req});
        if (exp_req) check("req_addr", ibus_req_addr, exp_addr);
        check("inst_valid", {63'd0, inst_valid}, {63'd0, m_buf_v});
        if (m_buf_v) begin
            check("inst", {32'd0, inst}, {32'd0, m_inst});
            check("inst_pc", inst_pc, m_inst_pc);
        end
    endtask

    // Clock edge: advance the model with the inputs of the cycle just checked.
    task automatic advance();
        logic hs, acc, cur_k, live_after;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            hs         = m_buf_v && inst_ready;
            cur_k      = m_live && m_killed;
            live_after = exp_req && !ibus_resp_data_ok;
            acc        = exp_req && ibus_resp_data_ok && !cur_k && !redirect_valid;
            if (redirect_valid) begin
                m_buf_v = 1'b0;
                m_pc    = redirect_pc & ~64'h3;
                m_wait  = 1'b0;
            end else if (acc) begin
                m_buf_v   = 1'b1;
                m_inst    = ibus_resp_data;
                m_inst_pc = exp_addr;
                m_pc      = exp_addr + 64'd4;
                m_wait    = !inst_ready;
            end else if (hs) begin
                m_buf_v = 1'b0;
                m_wait  = 1'b0;
            end
            m_killed = live_after && (cur_k || redirect_valid);
            m_live   = live_after;
            if (live_after) begin
                m_req_addr = exp_addr;
                age++;
            end else begin
                age = 0;
                if (rand_lat) lat = $urandom_range(0, 3);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 64'd0, 1'b0);
        advance();
        apply(1'b1, 1'b0, 64'd0, 1'b0);
        check("rst_req_valid", {63'd0, ibus_req_valid}, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst", {32'd0, inst}, {32'd0, NOP});
        check("rst_inst_pc", inst_pc, 64'd0);
        advance();
    endtask

    initial begin
        logic [63:0] tgt;
        logic        r, rv, rdy;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        ibus_resp_data_ok = 1'b0; ibus_resp_data = '0; ibus_resp_addr_ok = 1'b0;
        rand_lat = 1'b0; lat = 1; fixed_data_en = 1'b1; fixed_data = 32'h0050_0093;
        model_reset();
        @(negedge clk);

        // Basic fetch with a 1-cycle bus and decode always ready.
        do_reset();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t1_addr0", ibus_req_addr, PC0);
        advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t1_inst", {32'd0, inst}, 64'h0050_0093);
        check("t1_inst_pc", inst_pc, PC0);
        check("t1_req1", {63'd0, ibus_req_valid}, 64'd1);
        check("t1_addr1", ibus_req_addr, PC0 + 64'd4);
        advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        advance();

        // Back-pressure: decode stalls five cycles after the first fetch.
        do_reset();
        apply(1'b0, 1'b0, 64'd0, 1'b0); advance();
        apply(1'b0, 1'b0, 64'd0, 1'b0); advance();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 64'd0, 1'b0);
            check("t2_stall_req", {63'd0, ibus_req_valid}, 64'd0);
            check("t2_stall_pc", inst_pc, PC0);
            advance();
        end
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t2_hs_req", {63'd0, ibus_req_valid}, 64'd0);
        advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t2_next_req", {63'd0, ibus_req_valid}, 64'd1);
        check("t2_next_addr", ibus_req_addr, PC0 + 64'd4);
        advance();

        // Redirect while a slow request is in flight.
        do_reset();
        lat = 1;
        apply(1'b0, 1'b0, 64'd0, 1'b1); advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1); advance();
        lat = 3;
        apply(1'b0, 1'b0, 64'd0, 1'b1); advance();
        apply(1'b0, 1'b1, 64'h8000_0100, 1'b1); advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t3_held_addr", ibus_req_addr, PC0 + 64'd4);
        check("t3_flushed", {63'd0, inst_valid}, 64'd0);
        advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t3_held_addr2", ibus_req_addr, PC0 + 64'd4);
        advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t3_target_addr", ibus_req_addr, 64'h8000_0100);
        check("t3_no_data", {63'd0, inst_valid}, 64'd0);
        advance();

        // Redirect in the same cycle as data_ok.
        do_reset();
        lat = 1;
        apply(1'b0, 1'b0, 64'd0, 1'b1); advance();
        apply(1'b0, 1'b1, 64'h8000_0202, 1'b1); advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t4_addr", ibus_req_addr, 64'h8000_0200);
        check("t4_dropped", {63'd0, inst_valid}, 64'd0);
        advance();

        // pc wraps from the top of the address space to 0.
        do_reset();
        lat = 0;
        apply(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1); advance();
        lat = 1;
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t5_top_addr", ibus_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1); advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t5_wrap_addr", ibus_req_addr, 64'd0);
        check("t5_top_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        advance();

        // Reset in the middle of an outstanding request.
        do_reset();
        lat = 3;
        apply(1'b0, 1'b0, 64'd0, 1'b1); advance();
        apply(1'b1, 1'b0, 64'd0, 1'b1);
        check("t6_rst_req", {63'd0, ibus_req_valid}, 64'd0);
        advance();
        apply(1'b1, 1'b0, 64'd0, 1'b1);
        check("t6_rst_req2", {63'd0, ibus_req_valid}, 64'd0);
        check("t6_rst_valid", {63'd0, inst_valid}, 64'd0);
        advance();
        apply(1'b0, 1'b0, 64'd0, 1'b1);
        check("t6_refetch", ibus_req_addr, PC0);
        advance();

        // Randomized traffic against the model.
        rand_lat = 1'b1;
        fixed_data_en = 1'b0;
        lat = $urandom_range(0, 3);
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       tgt = {$urandom, $urandom};
                1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                2:       tgt = PC0 + 64'($urandom_range(0, 255));
                default: tgt = 64'($urandom_range(0, 1023));
            endcase
            apply(r, rv, tgt, rdy);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the single-issue RISC-V core. It owns the PC register, issues word fetches on the instruction bus, and buffers the returned instruction for one entry. It presents `inst` and `inst_pc` to the decode/control stage over a valid/ready handshake, and it accepts PC redirects from the execute stage: branch, JAL and JALR targets.

## Interface
Parameters:
- `XLEN`, 64: PC and address width.
- `PC_INIT`, 64'h8000_0000: first fetch address after reset.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `ibus_req_valid` output 1: fetch request valid.
- `ibus_req_addr` output XLEN: fetch address, always word-aligned.
- `ibus_resp_addr_ok` input 1: address accepted; informational only, not used for control.
- `ibus_resp_data_ok` input 1: response data valid this cycle; ends the request.
- `ibus_resp_data` input 32: fetched instruction word.
- `inst_valid` output 1: `inst`/`inst_pc` hold a live instruction.
- `inst_ready` input 1: decode consumes the instruction this cycle.
- `inst` output 32: instruction word to decode; opcode = [6:0], funct3 = [14:12], funct7 = [31:25].
- `inst_pc` output XLEN: address of `inst`.
- `redirect_valid` input 1: execute requests a PC change.
- `redirect_pc` input XLEN: new fetch target. Bits [1:0] are ignored and forced to 0.

## Operation
- **States:**
  - REQ: `ibus_req_valid`=1, `ibus_req_addr`=pc.
  - HOLD: buffer full, no request.
- **Bus rule:** once raised, `ibus_req_valid` and `ibus_req_addr` are held stable until `ibus_resp_data_ok`. A request is never withdrawn.
- **REQ with `data_ok`, not killed:**
  - Write `{ibus_resp_data, pc}` into the buffer, set `inst_valid`, set pc <= pc+4.
  - Go to REQ if the buffer drains in the same cycle (`inst_ready`), else go to HOLD.
- **HOLD:** on `inst_valid && inst_ready`, clear the buffer and go to REQ.
- **Redirect (any state):**
  - pc <= {`redirect_pc`[XLEN-1:2], 2'b00}.
  - The buffer is flushed: `inst_valid`=0 next cycle.
  - If a request is outstanding without `data_ok` this cycle, set `kill`.
  - Next state is REQ.
- **Killed request:** its `data_ok` is discarded; nothing is written to the buffer and pc is not incremented. `kill` clears on that `data_ok`. Because the old request is still in flight, the next request to the redirect target starts the cycle after `kill` clears.
- **Redirect in the same cycle as `data_ok`:** the data is dropped, `kill` stays 0, and a REQ to the redirect target starts next cycle.
- **Redirect while `kill`=1:** pc takes the newest target and `kill` stays 1.
- **Redirect in the same cycle as `inst_valid && inst_ready`:** the handshake completes (decode took it); the flush still applies.
- **pc arithmetic:** pc+4 is modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal.
- **Reset values:**
  - State REQ, pc = `PC_INIT`, `kill`=0.
  - `inst_valid`=0, `inst`=32'h0000_0013 (NOP), `inst_pc`=0.
  - `ibus_req_valid`=0 during reset.

## Timing
- **First fetch:** the cycle after `reset` falls, `ibus_req_valid`=1 and `ibus_req_addr`=`PC_INIT`.
- **Load latency:** `data_ok` in cycle N gives `inst_valid`=1 in N+1 (registered output).
- **Next request after `data_ok` in cycle N:**
  - Issued in N+1 if `inst_ready` was 1 in N+1.
  - Otherwise issued in the cycle after the handshake.
- **Peak throughput:** with a 1-cycle bus, one instruction per 2 cycles. Pipelining fetches is out of scope.
- **Redirect in cycle N:** `inst_valid`=0 in N+1. With no outstanding request, `ibus_req_addr`=target in N+1.
- **Outputs under back-pressure:** `inst`/`inst_pc` are stable while `inst_valid && !inst_ready`.
- **Reset mid-request:** reset overrides everything the same cycle. Any later stray `data_ok` before the first new request is ignored.

## Structure
- **Shared package (`defines`/`common`):**
  - `fetch_state_t` enum {REQ, HOLD}.
  - `PC_INIT` default.
  - `NOP_INST` = 32'h0000_0013.
  - The ibus request/response field widths.
- **Sub-module `inst_buffer`:** one-entry register of {inst, pc, valid} with load, pop and flush inputs.
- **`fetch_unit` itself:** holds pc, `kill` and the FSM.

## Test plan
- Reset, then the bus returns `data_ok` 1 cycle after each request with data 32'h00500093, `inst_ready`=1 → fetches at 0x8000_0000 and 0x8000_0004; `inst`=32'h00500093 with `inst_pc`=0x8000_0000 one cycle after the first `data_ok`.
- `inst_ready`=0 for 5 cycles after the first fetch → `ibus_req_valid`=0 throughout; `inst`/`inst_pc` stable; next request to 0x8000_0004 the cycle after `inst_ready` rises.
- Redirect to 0x8000_0100 while a request to 0x8000_0004 waits 3 cycles for `data_ok` → the request to 0x8000_0004 is held until `data_ok`; its data is never presented; the next request is to 0x8000_0100.
- Redirect to 0x8000_0202 in the same cycle as `data_ok` → data dropped; next request address 0x8000_0200.
- pc = 64'hFFFF_FFFF_FFFF_FFFC, fetch completes → next request address 0.
- Reset asserted during an outstanding request → next cycle `inst_valid`=0 and `ibus_req_valid`=0; after reset falls, fetch at `PC_INIT`.
